// File: rtl/assertion_monitor.sv
// assertion_monitor: warm-up gated property checker with sticky fail, counters, first-fail capture; optional history buffer via ASSERT_MON_HISTORY_EN
module assertion_monitor #(
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16,
  parameter int WARMUP     = 2,
  parameter int HIST_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  output logic              fail,
  output logic              fail_pulse,
  output logic [CNT_W-1:0]  violations,
  output logic [TS_W-1:0]   timestamp,
  output logic [TS_W-1:0]   first_fail_time,
  output logic [DATA_W-1:0] first_fail_data,
  output logic [1:0]        state
`ifdef ASSERT_MON_HISTORY_EN
  ,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_addr,
  output logic [DATA_W-1:0]             hist_data
`endif
);
  typedef enum logic [1:0] {WARM = 2'd0, ARMED = 2'd1, FAILED = 2'd2} state_t;
  localparam int WC_W = WARMUP > 0 ? $clog2(WARMUP + 1) : 1;
  localparam state_t INIT = WARMUP == 0 ? ARMED : WARM;
  state_t st;
  logic [WC_W-1:0] wcnt;
  logic holds;
  logic viol;
  assign state = st;
  // only an explicit 1 counts as holding, so X/Z on valid_in fails safe
  always_comb begin
    holds = 1'b0;
    if (valid_in) holds = 1'b1;
  end
  assign viol = en && !holds && st != WARM;
`ifdef ASSERT_MON_HISTORY_EN
  localparam int AW = $clog2(HIST_DEPTH);
  logic [DATA_W-1:0] hist [HIST_DEPTH];
  logic [AW-1:0] wp;
  assign hist_data = hist[wp - AW'(1) - hist_addr];
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wp <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (en && st != FAILED) begin
      hist[wp] <= data_in;
      wp <= wp + AW'(1);
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      st <= INIT;
      wcnt <= '0;
      fail <= 1'b0;
      fail_pulse <= 1'b0;
      violations <= '0;
      timestamp <= '0;
      first_fail_time <= '0;
      first_fail_data <= '0;
    end else begin
      fail_pulse <= 1'b0;
      if (en) begin
        timestamp <= timestamp + TS_W'(timestamp != '1);
        if (st == WARM) begin
          wcnt <= wcnt + WC_W'(1);
          if (wcnt == WC_W'(WARMUP - 1)) st <= ARMED;
        end
        if (viol) begin
          violations <= violations + CNT_W'(violations != '1);
          if (st == ARMED) begin
            st <= FAILED;
            fail <= 1'b1;
            fail_pulse <= 1'b1;
            first_fail_time <= timestamp;
            first_fail_data <= data_in;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_assertion_monitor.sv
// tb_assertion_monitor: randomized and directed checks against a cycle-level behavioural model
module tb_assertion_monitor;
  localparam int DW = 4, CW = 8, TW = 16, WU = 2, HD = 4;
  logic clk = 0, rst = 0, en = 0, valid_in = 1, clear = 0;
  logic [DW-1:0] data_in = 0;
  logic fail, fail_pulse;
  logic [CW-1:0] violations;
  logic [TW-1:0] timestamp, first_fail_time;
  logic [DW-1:0] first_fail_data;
  logic [1:0] state;
`ifdef ASSERT_MON_HISTORY_EN
  logic [$clog2(HD)-1:0] hist_addr = 0;
  logic [DW-1:0] hist_data;
`endif
  int checks = 0, errors = 0;
  bit m_fail, m_pulse;
  int m_viol, m_ts, m_ecnt, m_fft, m_ffd;
  int m_hist [HD];
  wire [47:0] act = {fail, fail_pulse, violations, timestamp, first_fail_time, first_fail_data, state};

  assertion_monitor #(.DATA_W(DW), .CNT_W(CW), .TS_W(TW), .WARMUP(WU), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .data_in(data_in), .clear(clear),
    .fail(fail), .fail_pulse(fail_pulse), .violations(violations), .timestamp(timestamp),
    .first_fail_time(first_fail_time), .first_fail_data(first_fail_data), .state(state)
`ifdef ASSERT_MON_HISTORY_EN
    , .hist_addr(hist_addr), .hist_data(hist_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] exp_vec();
    int s;
    s = m_fail ? 2 : (m_ecnt >= WU ? 1 : 0);
    return {m_fail, m_pulse, CW'(m_viol), TW'(m_ts), TW'(m_fft), DW'(m_ffd), 2'(s)};
  endfunction

  task automatic tick(input logic r, input logic e, input logic v, input logic c, input logic [DW-1:0] d);
    bit checked;
    rst = r; en = e; valid_in = v; clear = c; data_in = d;
    @(posedge clk);
    if (!r || c) begin
      m_fail = 0; m_pulse = 0; m_viol = 0; m_ts = 0; m_ecnt = 0; m_fft = 0; m_ffd = 0;
      for (int i = 0; i < HD; i++) m_hist[i] = 0;
    end else begin
      m_pulse = 0;
      if (e) begin
        if (!m_fail) begin
          for (int i = HD - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = d;
        end
        checked = m_fail || m_ecnt >= WU;
        if (checked && v !== 1'b1) begin
          if (!m_fail) begin
            m_fail = 1; m_pulse = 1; m_fft = m_ts; m_ffd = d;
          end
          m_viol = m_viol < 255 ? m_viol + 1 : 255;
        end
        m_ts = m_ts < 65535 ? m_ts + 1 : 65535;
        m_ecnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, 1, 0, 0, 4'hf);
    checks++;
    if (act !== 48'h0) begin errors++; $display("FAIL reset got %h exp %h", act, 48'h0); end
    checks++;
    if (act !== exp_vec()) begin errors++; $display("FAIL reset_model got %h exp %h", act, exp_vec()); end
  endtask

  task automatic test_warmup();
    tick(1, 1, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || fail !== 1'b0) begin errors++; $display("FAIL warm1 got state %0d fail %0b exp 0 0", state, fail); end
    tick(1, 1, 0, 0, 2);
    checks++;
    if (state !== 2'd1 || fail !== 1'b0) begin errors++; $display("FAIL warm2 got state %0d fail %0b exp 1 0", state, fail); end
    for (int i = 0; i < 8; i++) tick(1, 1, 1, 0, DW'($urandom));
    checks++;
    if (timestamp !== 16'd10 || violations !== 8'd0 || state !== 2'd1) begin
      errors++; $display("FAIL warm_run got ts %0d viol %0d state %0d exp 10 0 1", timestamp, violations, state);
    end
  endtask

  task automatic test_first_fail();
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, DW'(i));
    tick(1, 1, 0, 0, 4'd5);
    checks++;
    if (act !== {1'b1, 1'b1, 8'd1, 16'd6, 16'd5, 4'd5, 2'd2}) begin
      errors++; $display("FAIL first_fail got %h exp %h", act, {1'b1, 1'b1, 8'd1, 16'd6, 16'd5, 4'd5, 2'd2});
    end
    tick(1, 1, 1, 0, 4'd9);
    checks++;
    if (fail_pulse !== 1'b0 || fail !== 1'b1 || violations !== 8'd1) begin
      errors++; $display("FAIL pulse_one got pulse %0b fail %0b viol %0d exp 0 1 1", fail_pulse, fail, violations);
    end
    checks++;
    if (act !== exp_vec()) begin errors++; $display("FAIL first_fail_model got %h exp %h", act, exp_vec()); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) tick(1, 1, 0, 0, DW'($urandom));
    checks++;
    if (violations !== 8'd255 || first_fail_time !== 16'd5 || first_fail_data !== 4'd5 || state !== 2'd2) begin
      errors++; $display("FAIL saturate got viol %0d fft %0d ffd %0d state %0d exp 255 5 5 2",
                         violations, first_fail_time, first_fail_data, state);
    end
  endtask

  task automatic test_clear_rst_hold();
    tick(1, 1, 0, 1, 4'd3);
    checks++;
    if (act !== 48'h0) begin errors++; $display("FAIL clear got %h exp %h", act, 48'h0); end
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 4'd7);
    checks++;
    if (fail !== 1'b1 || first_fail_time !== 16'd2 || violations !== 8'd1) begin
      errors++; $display("FAIL refail got fail %0b fft %0d viol %0d exp 1 2 1", fail, first_fail_time, violations);
    end
    tick(0, 1, 0, 0, 4'd7);
    checks++;
    if (act !== 48'h0) begin errors++; $display("FAIL rst_failed got %h exp %h", act, 48'h0); end
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 4'd1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 4'd2);
    checks++;
    if (timestamp !== 16'd3 || fail !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL en_hold got ts %0d fail %0b state %0d exp 3 0 1", timestamp, fail, state);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      tick(($urandom % 60) != 0, ($urandom % 4) != 0, ($urandom % 10) != 0, ($urandom % 80) == 0, DW'($urandom));
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL random[%0d] got %h exp %h", n, act, exp_vec()); end
    end
  endtask

`ifdef ASSERT_MON_HISTORY_EN
  task automatic test_history();
    logic [DW-1:0] want [HD] = '{4'd5, 4'd4, 4'd3, 4'd2};
    tick(0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) tick(1, 1, 1, 0, DW'(i));
    tick(1, 1, 0, 0, 4'd5);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < HD; k++) begin
        hist_addr = 2'(k);
        #1;
        checks++;
        if (hist_data !== want[k] || hist_data !== DW'(m_hist[k])) begin
          errors++; $display("FAIL hist[%0d] pass %0d got %0d exp %0d", k, pass, hist_data, want[k]);
        end
      end
      for (int i = 0; i < 4; i++) tick(1, 1, $urandom % 2, 0, DW'(8 + i));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_warmup();
    test_first_fail();
    test_saturate();
    test_clear_rst_hold();
    test_random();
`ifdef ASSERT_MON_HISTORY_EN
    test_history();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/assertion_monitor.md
Name: assertion_monitor

Overview:
Downstream checker stage for a property-output block: consumes a 1-bit per-cycle property result (`valid_in`, 1 = holds) and a DATA_W snapshot of the observed design value (e.g. a 4-bit counter). It ignores a configurable warm-up window, latches the first violation sticky, and counts violations. It records the timestamp and data snapshot at the first failure. Its outputs feed the simulation/formal harness status registers.

Parameters:
DATA_W, 4, width of `data_in` snapshot and `first_fail_data`
CNT_W, 8, width of saturating violation counter
TS_W, 16, width of saturating cycle timestamp
WARMUP, 2, number of enabled cycles after reset/restart during which `valid_in` is ignored (0 = none)
HIST_DEPTH, 4, history buffer depth when ASSERT_MON_HISTORY_EN is defined (power of 2, >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low; sampled on rising `clk`
en  input  1  monitor enable; when 0 all state holds (no timestamp advance, no checks)
valid_in  input  1  property result this cycle, 1 = holds
data_in  input  DATA_W  design value sampled alongside `valid_in`
clear  input  1  clears fail status and counters, restarts warm-up
fail  output  1  sticky: 1 once any counted violation has occurred
fail_pulse  output  1  registered, 1 for exactly one cycle on the first counted violation
violations  output  CNT_W  number of counted violations, saturating at all-ones
timestamp  output  TS_W  number of enabled cycles since reset/clear, saturating
first_fail_time  output  TS_W  `timestamp` value at the cycle of first violation
first_fail_data  output  DATA_W  `data_in` at the cycle of first violation
state  output  2  0 = WARMUP, 1 = ARMED, 2 = FAILED (3 unused)

Behaviour:
- Reset (`rst`=0 at edge): state=WARMUP (ARMED if WARMUP=0), fail=0, fail_pulse=0, violations=0, timestamp=0, first_fail_time=0, first_fail_data=0, warm-up counter=0.
- All outputs are registered; a violation sampled at edge N is visible after edge N (1-cycle latency).
- Priority at each edge: `rst` > `clear` > `en`=0 hold > normal operation.
- `clear`=1 (with `rst`=1): same values as reset, independent of `en`.
- Timestamp: increments by 1 on every edge with `en`=1 in any state; saturates at 2^TS_W-1.
- WARMUP: the warm-up counter increments on each enabled edge. `valid_in` is ignored. After WARMUP enabled edges, state becomes ARMED; the next enabled edge is the first checked one.
- ARMED: if `en` & !`valid_in`, then state becomes FAILED, fail=1, fail_pulse=1, violations incremented, first_fail_time=current `timestamp` (pre-increment), first_fail_data=`data_in`.
- FAILED: each `en` & !`valid_in` increments violations (saturating). first_fail_* frozen; fail_pulse=0. Only `rst`/`clear` leave FAILED.
- fail_pulse deasserts on the next edge regardless of `en`.
- Violation with `clear`=1 on the same edge: `clear` wins; the violation is not counted.
- X on `valid_in` while checking: treated as violation (fail-safe).

Optional Feature:
ASSERT_MON_HISTORY_EN: when defined, adds input `hist_addr` (log2(HIST_DEPTH) bits) and output `hist_data` (DATA_W bits, combinational read).
- A circular buffer captures `data_in` on every enabled edge while state != FAILED.
- The buffer freezes on the first violation; the violating sample is included.
- `hist_addr`=0 returns the newest (violating) sample; `hist_addr`=k returns the sample k enabled cycles older.
- Reset/`clear` zero the buffer.
- When the macro is not defined, these ports and the buffer do not exist; all other behaviour is identical.

Test Plan:
- Reset then `en`=1, `valid_in`=1 for 10 cycles -> state 0,0,1,... ; fail=0; violations=0; timestamp=10.
- WARMUP=2, `valid_in`=0 on enabled cycles 1-2, then 1 -> no fail; state reaches ARMED after edge 2.
- Armed at timestamp=5, `data_in`=4'd5, `valid_in`=0 -> next cycle fail=1, fail_pulse=1 for one cycle, first_fail_time=5, first_fail_data=5, violations=1, state=2.
- FAILED, 300 further violations with CNT_W=8 -> violations saturates at 255; first_fail_* unchanged.
- `clear`=1 same edge as violation, then `rst`=0 mid-FAILED -> clear: all zero, state WARMUP; rst: same; `en`=0 for 5 cycles holds timestamp.
- ASSERT_MON_HISTORY_EN, HIST_DEPTH=4, `data_in`=1,2,3,4,5 with violation at 5 -> `hist_data` at addr 0..3 = 5,4,3,2; unchanged after further `data_in` changes.
